// File: rtl/ultrasonic_echo_meter_if.sv
// ultrasonic_echo_meter_if: sensor-side control and measurement result signals of the echo meter
interface ultrasonic_echo_meter_if;
    logic        enable;
    logic        echo;
    logic        trigger;
    logic [19:0] contador2;
    logic        meas_valid;
    logic        timeout;
    logic        busy;
    modport master (output enable, echo, input trigger, contador2, meas_valid, timeout, busy);
    modport slave (input enable, echo, output trigger, contador2, meas_valid, timeout, busy);
endinterface

// File: rtl/ultrasonic_echo_meter.sv
// ultrasonic_echo_meter: periodic HC-SR04 trigger generator and echo pulse width timer
module ultrasonic_echo_meter #(
    parameter int          TRIG_CYCLES   = 500,
    parameter int          PERIOD_CYCLES = 3000000,
    parameter int          RISE_TIMEOUT  = 1000000,
    parameter logic [19:0] MAX_COUNT     = 20'hFFFFF
) (
    input logic                    clk,
    input logic                    rst,
    ultrasonic_echo_meter_if.slave bus_io
);
    localparam logic [19:0] TRIG_LAST   = 20'(TRIG_CYCLES - 1);
    localparam logic [19:0] RISE_LAST   = 20'(RISE_TIMEOUT - 1);
    localparam logic [21:0] PERIOD_LAST = 22'(PERIOD_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;
    state_t      state_q;
    logic [1:0]  sync_q;
    logic [19:0] cnt_q;
    logic [21:0] period_q;
    logic        trigger_q;
    logic [19:0] contador2_q;
    logic        meas_valid_q;
    logic        timeout_q;
    logic        busy_q;
    logic        echo_s;
    assign echo_s = sync_q[1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            cnt_q        <= '0;
            period_q     <= '0;
            trigger_q    <= 1'b0;
            contador2_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], bus_io.echo};
            meas_valid_q <= 1'b0;
            if (state_q != IDLE) period_q <= period_q + 22'd1;
            case (state_q)
                IDLE: if (bus_io.enable) begin
                    state_q   <= TRIG;
                    busy_q    <= 1'b1;
                    trigger_q <= 1'b1;
                    period_q  <= '0;
                    cnt_q     <= '0;
                end
                TRIG: if (cnt_q == TRIG_LAST) begin
                    state_q   <= WAIT_ECHO;
                    trigger_q <= 1'b0;
                    cnt_q     <= '0;
                end else cnt_q <= cnt_q + 20'd1;
                WAIT_ECHO: if (echo_s) begin
                    state_q <= MEASURE;
                    cnt_q   <= 20'd1;
                end else if (cnt_q == RISE_LAST) begin
                    state_q      <= HOLDOFF;
                    contador2_q  <= MAX_COUNT;
                    timeout_q    <= 1'b1;
                    meas_valid_q <= 1'b1;
                end else cnt_q <= cnt_q + 20'd1;
                // Reaching MAX_COUNT reports saturation, so a valid width never equals it
                MEASURE: if (!echo_s || cnt_q == MAX_COUNT - 20'd1) begin
                    state_q      <= HOLDOFF;
                    contador2_q  <= echo_s ? MAX_COUNT : cnt_q;
                    timeout_q    <= echo_s;
                    meas_valid_q <= 1'b1;
                end else cnt_q <= cnt_q + 20'd1;
                HOLDOFF: if (period_q == PERIOD_LAST) begin
                    state_q   <= bus_io.enable ? TRIG : IDLE;
                    busy_q    <= bus_io.enable;
                    trigger_q <= bus_io.enable;
                    period_q  <= '0;
                    cnt_q     <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign bus_io.trigger    = trigger_q;
    assign bus_io.contador2  = contador2_q;
    assign bus_io.meas_valid = meas_valid_q;
    assign bus_io.timeout    = timeout_q;
    assign bus_io.busy       = busy_q;
endmodule
